// File: rtl/mux_ctrl.sv
// Host-side project wrapper multiplexer: serial address load, safe switch sequence
// (drain gap, held reset, active) and registered return path from the selected wrapper.
module mux_ctrl #(
    parameter int unsigned NPROJ   = 16,
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned GAP_CYC = 4,
    parameter int unsigned RST_CYC = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sel_shift,
    input  logic                  sel_din,
    input  logic                  sel_commit,
    input  logic                  proj_clk,
    input  logic                  proj_rst_n,
    input  logic [7:0]            ui_in,
    input  logic [7:0]            uio_in,
    output logic [17:0]           iw,
    output logic [NPROJ-1:0]      ena,
    input  logic [NPROJ*24-1:0]   ow_all,
    output logic [7:0]            uo_out,
    output logic [7:0]            uio_out,
    output logic [7:0]            uio_oe,
    output logic [ADDR_W-1:0]     cur_addr,
    output logic                  sel_valid
);

    localparam int unsigned CNT_MAX = (GAP_CYC > RST_CYC) ? GAP_CYC : RST_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRAIN  = 2'd1,
        S_RESET  = 2'd2,
        S_ACTIVE = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_sr_q, addr_sr_d;
    logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NPROJ-1:0]    ena_q, ena_d;
    logic                sel_valid_q, sel_valid_d;
    logic [23:0]         ret_q, ret_d;

    logic [23:0]         ow_arr [NPROJ];
    logic [23:0]         sel_ow_c;
    logic                commit_take_c;
    logic                in_range_c;
    logic                proj_on_d_c;

    for (genvar g = 0; g < NPROJ; g++) begin : g_slice
        assign ow_arr[g] = ow_all[g*24 +: 24];
    end

    // Return-path select for the currently addressed wrapper
    always_comb begin
        sel_ow_c = '0;
        for (int unsigned k = 0; k < NPROJ; k++) begin
            if (32'(cur_addr_q) == k) sel_ow_c = ow_arr[k];
        end
    end

    // Next-state logic; a same-address recommit while ACTIVE is dropped to avoid a glitch
    always_comb begin
        state_d     = state_q;
        addr_sr_d   = addr_sr_q;
        cur_addr_d  = cur_addr_q;
        cnt_d       = cnt_q;
        ena_d       = '0;
        sel_valid_d = 1'b0;
        ret_d       = '0;

        in_range_c    = 32'(cur_addr_q) < NPROJ;
        commit_take_c = sel_commit &&
                        !((state_q == S_ACTIVE) && (addr_sr_q == cur_addr_q));

        if (sel_shift) addr_sr_d = ADDR_W'({addr_sr_q, sel_din});

        case (state_q)
            S_DRAIN: begin
                if (cnt_q <= CNT_W'(1)) begin
                    if (in_range_c) begin
                        state_d = S_RESET;
                        cnt_d   = CNT_W'(RST_CYC);
                    end else begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESET: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = S_ACTIVE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: ;
        endcase

        if (commit_take_c) begin
            state_d    = S_DRAIN;
            cur_addr_d = addr_sr_q;
            cnt_d      = CNT_W'(GAP_CYC);
        end

        // Enables follow the next state so they leave the flop aligned with it
        proj_on_d_c = (state_d == S_RESET) || (state_d == S_ACTIVE);
        for (int unsigned k = 0; k < NPROJ; k++) begin
            ena_d[k] = proj_on_d_c && (32'(cur_addr_d) == k);
        end
        sel_valid_d = (state_d == S_ACTIVE);

        if (state_q == S_ACTIVE) ret_d = sel_ow_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_sr_q   <= '0;
            cur_addr_q  <= '0;
            cnt_q       <= '0;
            ena_q       <= '0;
            sel_valid_q <= 1'b0;
            ret_q       <= '0;
        end else begin
            state_q     <= state_d;
            addr_sr_q   <= addr_sr_d;
            cur_addr_q  <= cur_addr_d;
            cnt_q       <= cnt_d;
            ena_q       <= ena_d;
            sel_valid_q <= sel_valid_d;
            ret_q       <= ret_d;
        end
    end

    // Project clock and reset only reach the wrapper while it is enabled
    assign iw = {uio_in, ui_in,
                 proj_rst_n & (state_q == S_ACTIVE),
                 proj_clk & ((state_q == S_RESET) || (state_q == S_ACTIVE))};

    assign ena       = ena_q;
    assign sel_valid = sel_valid_q;
    assign cur_addr  = cur_addr_q;
    assign uo_out    = ret_q[7:0];
    assign uio_out   = ret_q[15:8];
    assign uio_oe    = ret_q[23:16];

endmodule

// File: tb/tb_mux_ctrl.sv
// Bench for mux_ctrl: two instances (16 and 12 projects) checked every cycle against a
// time-since-commit model, plus directed literal expectations for each switch scenario.
module tb_mux_ctrl;

    localparam int G = 4;
    localparam int R = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, sel_shift = 1'b0, sel_din = 1'b0, sel_commit = 1'b0;
    logic proj_clk = 1'b0, proj_rst_n = 1'b0;
    logic [7:0] ui_in = 8'h00, uio_in = 8'h00;
    logic [23:0] owv [16];
    logic [16*24-1:0] ow_a;
    logic [12*24-1:0] ow_b;

    for (genvar g = 0; g < 16; g++) begin : g_owa
        assign ow_a[g*24 +: 24] = owv[g];
    end
    for (genvar g = 0; g < 12; g++) begin : g_owb
        assign ow_b[g*24 +: 24] = owv[g];
    end

    logic [17:0] iw_a, iw_b;
    logic [15:0] ena_a;
    logic [11:0] ena_b;
    logic [7:0]  uo_a, uio_a, oe_a, uo_b, uio_b, oe_b;
    logic [3:0]  cur_a, cur_b;
    logic        sv_a, sv_b;

    mux_ctrl #(.NPROJ(16), .ADDR_W(4), .GAP_CYC(G), .RST_CYC(R)) u_a (
        .clk(clk), .rst(rst), .sel_shift(sel_shift), .sel_din(sel_din),
        .sel_commit(sel_commit), .proj_clk(proj_clk), .proj_rst_n(proj_rst_n),
        .ui_in(ui_in), .uio_in(uio_in), .iw(iw_a), .ena(ena_a), .ow_all(ow_a),
        .uo_out(uo_a), .uio_out(uio_a), .uio_oe(oe_a), .cur_addr(cur_a), .sel_valid(sv_a)
    );

    mux_ctrl #(.NPROJ(12), .ADDR_W(4), .GAP_CYC(G), .RST_CYC(R)) u_b (
        .clk(clk), .rst(rst), .sel_shift(sel_shift), .sel_din(sel_din),
        .sel_commit(sel_commit), .proj_clk(proj_clk), .proj_rst_n(proj_rst_n),
        .ui_in(ui_in), .uio_in(uio_in), .iw(iw_b), .ena(ena_b), .ow_all(ow_b),
        .uo_out(uo_b), .uio_out(uio_b), .uio_oe(oe_b), .cur_addr(cur_b), .sel_valid(sv_b)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a switch is just a target plus the number of edges since it was accepted
    int  np [2] = '{16, 12};
    bit  have [2];
    int  tgt [2];
    int  el [2];
    int  sr [2];
    logic [23:0] mout [2];
    bit  chk_en = 1'b0;

    function automatic bit m_on(input int i);
        return have[i] && (tgt[i] < np[i]) && (el[i] >= G);
    endfunction

    function automatic bit m_act(input int i);
        return have[i] && (tgt[i] < np[i]) && (el[i] >= G + R);
    endfunction

    function automatic logic [63:0] exp_ena(input int i);
        return m_on(i) ? (64'd1 << tgt[i]) : 64'd0;
    endfunction

    function automatic logic [63:0] exp_iw(input int i);
        return 64'({uio_in, ui_in, m_act(i) & proj_rst_n, m_on(i) & proj_clk});
    endfunction

    always @(posedge clk) begin
        bit act;
        bit take;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                have[i] = 1'b0; tgt[i] = 0; el[i] = 0; sr[i] = 0; mout[i] = 24'h0;
                chk_en  = 1'b1;
            end else begin
                act     = m_act(i);
                mout[i] = act ? owv[tgt[i]] : 24'h0;
                take    = sel_commit && !(act && (sr[i] == tgt[i]));
                if (take) begin
                    have[i] = 1'b1; tgt[i] = sr[i]; el[i] = 0;
                end else if (el[i] < G + R) begin
                    el[i]++;
                end
                if (sel_shift) sr[i] = ((sr[i] << 1) | int'(sel_din)) & 15;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("a_ena", 64'(ena_a), exp_ena(0));
            chk("a_valid", 64'(sv_a), 64'(m_act(0)));
            chk("a_cur", 64'(cur_a), 64'(tgt[0]));
            chk("a_out", 64'({oe_a, uio_a, uo_a}), 64'(mout[0]));
            chk("a_iw", 64'(iw_a), exp_iw(0));
            chk("a_onehot", 64'($countones(ena_a) <= 1), 64'd1);
            chk("b_ena", 64'(ena_b), exp_ena(1));
            chk("b_valid", 64'(sv_b), 64'(m_act(1)));
            chk("b_cur", 64'(cur_b), 64'(tgt[1]));
            chk("b_out", 64'({oe_b, uio_b, uo_b}), 64'(mout[1]));
            chk("b_iw", 64'(iw_b), exp_iw(1));
            chk("b_onehot", 64'($countones(ena_b) <= 1), 64'd1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        ui_in      = 8'($urandom);
        uio_in     = 8'($urandom);
        proj_clk   = 1'($urandom);
        proj_rst_n = 1'($urandom);
    endtask

    task automatic shift_addr(input logic [3:0] a);
        for (int b = 3; b >= 0; b--) begin
            sel_shift = 1'b1;
            sel_din   = a[b];
            step();
        end
        sel_shift = 1'b0;
        sel_din   = 1'b0;
    endtask

    task automatic commit();
        sel_commit = 1'b1;
        step();
        sel_commit = 1'b0;
    endtask

    initial begin
        logic [3:0] bits;
        for (int k = 0; k < 16; k++) owv[k] = 24'(32'h00010101 * (k + 1) + 32'h00800000);
        owv[5] = 24'hA5C33C;
        owv[6] = 24'h5A0FF0;

        // Reset
        step();
        step();
        rst = 1'b0;
        chk("rst_ena", 64'(ena_a), 64'h0);
        chk("rst_valid", 64'(sv_a), 64'h0);
        chk("rst_out", 64'({oe_a, uio_a, uo_a}), 64'h0);
        chk("rst_cur", 64'(cur_a), 64'h0);
        chk("rst_iw_lo", 64'(iw_a[1:0]), 64'h0);

        // Switch to project 5
        shift_addr(4'b0101);
        commit();
        chk("s2_ena0", 64'(ena_a), 64'h0);
        chk("s2_cur", 64'(cur_a), 64'h5);
        for (int k = 1; k <= 12; k++) begin
            step();
            chk("s2_ena", 64'(ena_a), (k >= 4) ? 64'h0020 : 64'h0);
            chk("s2_valid", 64'(sv_a), (k >= 12) ? 64'h1 : 64'h0);
            if (k < 12) chk("s2_iw1", 64'(iw_a[1]), 64'h0);
        end
        chk("s2_out_pre", 64'({oe_a, uio_a, uo_a}), 64'h0);
        step();
        chk("s2_out", 64'({oe_a, uio_a, uo_a}), 64'hA5C33C);
        owv[5] = 24'h123456;
        step();
        chk("s2_out_upd", 64'({oe_a, uio_a, uo_a}), 64'h123456);
        ui_in = 8'hC3; uio_in = 8'h3C; proj_clk = 1'b1; proj_rst_n = 1'b1;
        #1;
        chk("s2_iw", 64'(iw_a), 64'h0F30F);

        // Recommit of the active address is ignored
        commit();
        chk("s3_ena", 64'(ena_a), 64'h0020);
        chk("s3_valid", 64'(sv_a), 64'h1);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("s3_ena_n", 64'(ena_a), 64'h0020);
        end

        // 5 -> 7, overridden by 3 in the second RESET cycle of 7
        shift_addr(4'b0111);
        commit();
        chk("s4_ena_drop", 64'(ena_a), 64'h0);
        chk("s4_cur7", 64'(cur_a), 64'h7);
        bits = 4'b0011;
        for (int b = 3; b >= 0; b--) begin
            sel_shift = 1'b1;
            sel_din   = bits[b];
            step();
            chk("s4_ena7", 64'(ena_a), (b == 0) ? 64'h0080 : 64'h0);
        end
        sel_shift = 1'b0;
        sel_din   = 1'b0;
        step();
        chk("s4_ena7b", 64'(ena_a), 64'h0080);
        chk("s4_valid7", 64'(sv_a), 64'h0);
        commit();
        chk("s4_ena_off", 64'(ena_a), 64'h0);
        chk("s4_cur3", 64'(cur_a), 64'h3);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("s4_ena3", 64'(ena_a), (k == 4) ? 64'h0008 : 64'h0);
        end
        for (int k = 0; k < 8; k++) step();
        chk("s4_valid3", 64'(sv_a), 64'h1);

        // Out-of-range address on the 12-project instance
        shift_addr(4'b1101);
        commit();
        for (int k = 0; k < 6; k++) step();
        chk("s5_b_ena", 64'(ena_b), 64'h0);
        chk("s5_b_valid", 64'(sv_b), 64'h0);
        chk("s5_b_cur", 64'(cur_b), 64'hD);
        chk("s5_b_out", 64'({oe_b, uio_b, uo_b}), 64'h0);
        chk("s5_a_ena", 64'(ena_a), 64'h2000);

        // Reset mid-DRAIN
        shift_addr(4'b0010);
        commit();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("s6_ena_d", 64'(ena_a), 64'h0);
        chk("s6_cur_d", 64'(cur_a), 64'h0);
        for (int k = 0; k < 3; k++) step();
        chk("s6_idle", 64'(ena_a), 64'h0);

        // Reset mid-ACTIVE
        shift_addr(4'b0110);
        commit();
        for (int k = 0; k < 12; k++) step();
        chk("s6_valid", 64'(sv_a), 64'h1);
        chk("s6_ena6", 64'(ena_a), 64'h0040);
        step();
        chk("s6_out6", 64'({oe_a, uio_a, uo_a}), 64'h5A0FF0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("s6_ena_a", 64'(ena_a), 64'h0);
        chk("s6_valid_a", 64'(sv_a), 64'h0);
        chk("s6_out_a", 64'({oe_a, uio_a, uo_a}), 64'h0);
        chk("s6_cur_a", 64'(cur_a), 64'h0);
        for (int k = 0; k < 3; k++) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
